fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the branch predictor and the instruction queue.
- Holds the PC and requests 32-bit instructions from the icache.
- Predecodes JAL/branch instructions and queries the predictor with an 8-bit PC tag to select the next PC.
- Delivers {inst, pc, predicted-jump} to the instruction queue; on an ROB mispredict flush, redirects to the ROB target.

---
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches from the icache, predecodes JAL/branches and feeds the instruction queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  output logic                 out_icache_req,
  output logic [31:0]          out_icache_pc,
  input  logic                 in_icache_valid,
  input  logic [31:0]          in_icache_inst,
  output logic [TAG_WIDTH-1:0] out_bp_tag,
  input  logic                 in_bp_jump_res,
  input  logic                 in_queue_full,
  output logic                 out_queue_valid,
  output logic [31:0]          out_queue_inst,
  output logic [31:0]          out_queue_pc,
  output logic                 out_queue_pred_jump,
  input  logic                 in_rob_flush,
  input  logic [31:0]          in_rob_target_pc
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, next_pc, j_imm, b_imm, h_inst, h_pc, h_next;
  logic h_pred, pred, is_jal, is_br, take_new, take_hold;
  assign out_icache_pc = pc;
  assign out_bp_tag = pc[TAG_WIDTH+1:2];
  assign is_jal = in_icache_inst[6:0] == 7'b1101111;
  assign is_br = in_icache_inst[6:0] == 7'b1100011;
  assign j_imm = {{11{in_icache_inst[31]}}, in_icache_inst[31], in_icache_inst[19:12],
                  in_icache_inst[20], in_icache_inst[30:21], 1'b0};
  assign b_imm = {{19{in_icache_inst[31]}}, in_icache_inst[31], in_icache_inst[7],
                  in_icache_inst[30:25], in_icache_inst[11:8], 1'b0};
  assign pred = is_jal | (is_br & in_bp_jump_res);
  assign next_pc = is_jal ? pc + j_imm : pred ? pc + b_imm : pc + 32'd4;
  assign take_new = state == REQ && in_icache_valid && !in_queue_full;
  assign take_hold = state == HOLD && !in_queue_full;
  always_comb begin
    state_n = state;
    out_icache_req = state == REQ;
    state_n = in_rob_flush ? IDLE :
              state == IDLE ? REQ :
              state == REQ ? ((in_icache_valid && in_queue_full) ? HOLD : REQ) :
              (in_queue_full ? HOLD : REQ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      out_queue_valid <= 1'b0;
      out_queue_inst <= '0;
      out_queue_pc <= '0;
      out_queue_pred_jump <= 1'b0;
      h_inst <= '0;
      h_pc <= '0;
      h_next <= '0;
      h_pred <= 1'b0;
    end else if (rdy) begin
      state <= state_n;
      out_queue_valid <= 1'b0;
      if (in_rob_flush) begin
        pc <= in_rob_target_pc;
      end else if (take_new) begin
        out_queue_valid <= 1'b1;
        out_queue_inst <= in_icache_inst;
        out_queue_pc <= pc;
        out_queue_pred_jump <= pred;
        pc <= next_pc;
      end else if (state == REQ && in_icache_valid) begin
        h_inst <= in_icache_inst;
        h_pc <= pc;
        h_pred <= pred;
        h_next <= next_pc;
      end else if (take_hold) begin
        out_queue_valid <= 1'b1;
        out_queue_inst <= h_inst;
        out_queue_pc <= h_pc;
        out_queue_pred_jump <= h_pred;
        pc <= h_next;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table plus hand-written corner sequences, deliveries checked against a scoreboard queue.
module tb_fetch_unit;
  logic clk = 0, rst = 1, rdy = 1;
  logic icache_req, icache_valid = 0, bp_jump = 0, queue_full = 0, rob_flush = 0;
  logic q_valid, q_pred;
  logic [31:0] icache_pc, icache_inst = 0, q_inst, q_pc, rob_target = 0;
  logic [7:0] bp_tag;
  int compared = 0, mismatched = 0;
  typedef struct { logic [31:0] inst; logic [31:0] pc; logic pred; } exp_t;
  exp_t sb[$];
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic bp; logic pred; logic [31:0] next; } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .out_icache_req(icache_req), .out_icache_pc(icache_pc),
    .in_icache_valid(icache_valid), .in_icache_inst(icache_inst),
    .out_bp_tag(bp_tag), .in_bp_jump_res(bp_jump), .in_queue_full(queue_full),
    .out_queue_valid(q_valid), .out_queue_inst(q_inst), .out_queue_pc(q_pc),
    .out_queue_pred_jump(q_pred), .in_rob_flush(rob_flush), .in_rob_target_pc(rob_target)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // A delivery is consumed only on a cycle whose edge had rdy high.
  task automatic cyc();
    logic took;
    exp_t e;
    took = rdy;
    @(posedge clk);
    #1;
    if (took && q_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_delivery: got pc %h expected none", q_pc);
      end else begin
        e = sb.pop_front();
        chk("q_inst", q_inst, e.inst);
        chk("q_pc", q_pc, e.pc);
        chk("q_pred", {31'b0, q_pred}, {31'b0, e.pred});
      end
    end
  endtask
  task automatic redirect(input logic [31:0] target);
    rob_flush = 1;
    rob_target = target;
    cyc();
    rob_flush = 0;
    chk("flush_idle_req", {31'b0, icache_req}, 32'd0);
    cyc();
    chk("flush_req", {31'b0, icache_req}, 32'd1);
    chk("flush_pc", icache_pc, target);
  endtask
  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0010_0093, 1'b0, 1'b0, 32'h0000_0004};
    vecs[1] = '{32'h0000_0100, 32'h0080_006F, 1'b0, 1'b1, 32'h0000_0108};
    vecs[2] = '{32'h0000_0100, 32'h0080_006F, 1'b1, 1'b1, 32'h0000_0108};
    vecs[3] = '{32'h0000_0200, 32'hFE00_0EE3, 1'b1, 1'b1, 32'h0000_01FC};
    vecs[4] = '{32'h0000_0200, 32'hFE00_0EE3, 1'b0, 1'b0, 32'h0000_0204};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0010_0093, 1'b1, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'h0000_0040, 32'h0000_80E7, 1'b1, 1'b0, 32'h0000_0044};
    vecs[7] = '{32'h0000_0000, 32'hFE00_1EE3, 1'b1, 1'b1, 32'hFFFF_FFFC};
    cyc();
    cyc();
    rst = 0;
    chk("rst_req", {31'b0, icache_req}, 32'd0);
    chk("rst_pc", icache_pc, 32'd0);
    chk("rst_valid", {31'b0, q_valid}, 32'd0);
    chk("rst_qpc", q_pc, 32'd0);
    cyc();
    chk("first_req", {31'b0, icache_req}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      redirect(vecs[i].pc);
      chk("bp_tag", {24'b0, bp_tag}, {24'b0, vecs[i].pc[9:2]});
      icache_valid = 1;
      icache_inst = vecs[i].inst;
      bp_jump = vecs[i].bp;
      sb.push_back('{vecs[i].inst, vecs[i].pc, vecs[i].pred});
      cyc();
      icache_valid = 0;
      bp_jump = 0;
      chk("vec_valid", {31'b0, q_valid}, 32'd1);
      chk("vec_next_pc", icache_pc, vecs[i].next);
      chk("vec_req", {31'b0, icache_req}, 32'd1);
    end
    cyc();
    chk("valid_single_pulse", {31'b0, q_valid}, 32'd0);
    redirect(32'h10);
    queue_full = 1;
    icache_valid = 1;
    icache_inst = 32'h0010_0093;
    sb.push_back('{32'h0010_0093, 32'h10, 1'b0});
    cyc();
    icache_valid = 0;
    chk("hold_req", {31'b0, icache_req}, 32'd0);
    chk("hold_no_valid", {31'b0, q_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("hold_stay", {31'b0, icache_req | q_valid}, 32'd0);
    end
    queue_full = 0;
    cyc();
    chk("hold_deliver", {31'b0, q_valid}, 32'd1);
    chk("hold_next_pc", icache_pc, 32'h14);
    chk("hold_req_back", {31'b0, icache_req}, 32'd1);
    cyc();
    chk("hold_one_pulse", {31'b0, q_valid}, 32'd0);
    icache_valid = 1;
    rob_flush = 1;
    rob_target = 32'h400;
    cyc();
    icache_valid = 0;
    rob_flush = 0;
    chk("fv_no_valid", {31'b0, q_valid}, 32'd0);
    chk("fv_idle", {31'b0, icache_req}, 32'd0);
    chk("fv_pc", icache_pc, 32'h400);
    cyc();
    chk("fv_req", {31'b0, icache_req}, 32'd1);
    queue_full = 1;
    icache_valid = 1;
    cyc();
    icache_valid = 0;
    queue_full = 0;
    rob_flush = 1;
    rob_target = 32'h500;
    cyc();
    rob_flush = 0;
    chk("fh_no_valid", {31'b0, q_valid}, 32'd0);
    chk("fh_pc", icache_pc, 32'h500);
    cyc();
    chk("fh_req", {31'b0, icache_req}, 32'd1);
    cyc();
    chk("fh_never", {31'b0, q_valid}, 32'd0);
    rdy = 0;
    icache_inst = 32'h0080_006F;
    for (int i = 0; i < 4; i++) begin
      icache_valid = (i % 2) == 0;
      cyc();
      chk("rdy_pc", icache_pc, 32'h500);
      chk("rdy_req", {31'b0, icache_req}, 32'd1);
      chk("rdy_valid", {31'b0, q_valid}, 32'd0);
    end
    rdy = 1;
    icache_valid = 1;
    sb.push_back('{32'h0080_006F, 32'h500, 1'b1});
    cyc();
    icache_valid = 0;
    rdy = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rdy_valid_hold", {31'b0, q_valid}, 32'd1);
      chk("rdy_pc_hold", icache_pc, 32'h508);
    end
    rdy = 1;
    cyc();
    chk("rdy_release", {31'b0, q_valid}, 32'd0);
    queue_full = 1;
    icache_valid = 1;
    cyc();
    icache_valid = 0;
    chk("rst_hold_state", {31'b0, icache_req}, 32'd0);
    rst = 1;
    cyc();
    rst = 0;
    queue_full = 0;
    chk("rsth_pc", icache_pc, 32'd0);
    chk("rsth_req", {31'b0, icache_req}, 32'd0);
    chk("rsth_valid", {31'b0, q_valid}, 32'd0);
    chk("rsth_inst", q_inst, 32'd0);
    chk("rsth_qpc", q_pc, 32'd0);
    chk("rsth_pred", {31'b0, q_pred}, 32'd0);
    cyc();
    cyc();
    chk("rsth_req_after", {31'b0, icache_req}, 32'd1);
    chk("rsth_no_valid", {31'b0, q_valid}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
